regfile_sequencer: RTL

//  Write-side controller for the convolution SRAM line buffer (regfile).

---
 rtl/regfile_seq_pkg.sv | 22 ++
 rtl/onehot_ring.sv | 30 +++
 rtl/regfile_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/regfile_seq_pkg.sv
// Shared types and default geometry for the regfile write-side sequencer.
package regfile_seq_pkg;

    localparam int unsigned NUM_COLS_DEF = 9;
    localparam int unsigned PIX_W_DEF    = 8;
    localparam int unsigned NUM_ROWS_DEF = 3;

    localparam logic [2:0] MEMPTR_RESET = 3'b001;
    localparam logic [8:0] COL0_ONEHOT  = 9'b1_0000_0000;

    typedef enum logic [1:0] {
        WAIT,
        SCAN,
        WRITE
    } state_e;

    typedef enum logic {
        DIR_LEFT,
        DIR_RIGHT
    } dir_e;

endpackage

// File: rtl/onehot_ring.sv
// Rotating one-hot register: reloads RESET_VAL on reset or clear, rotates one step per advance.
module onehot_ring
    import regfile_seq_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(1),
    parameter dir_e             DIR       = DIR_LEFT
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             clear,
    input  logic             advance,
    output logic [WIDTH-1:0] ring
);

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            ring <= RESET_VAL;
        end else if (clear) begin
            ring <= RESET_VAL;
        end else if (advance) begin
            if (DIR == DIR_RIGHT) begin
                ring <= {ring[0], ring[WIDTH-1:1]};
            end else begin
                ring <= {ring[WIDTH-2:0], ring[WIDTH-1]};
            end
        end
    end

endmodule

// File: rtl/regfile_sequencer.sv
// Write-side sequencer for the convolution line-buffer regfile: per pixel, an
// 8-cycle bit-serial scan of the addressed column followed by one write cycle.
module regfile_sequencer
    import regfile_seq_pkg::*;
#(
    parameter int unsigned NUM_COLS = NUM_COLS_DEF,
    parameter int unsigned PIX_W    = PIX_W_DEF,
    parameter int unsigned NUM_ROWS = NUM_ROWS_DEF
) (
    input  logic                phi1,
    input  logic                reset_b_s1,
    input  logic                pix_valid_s1,
    input  logic [PIX_W-1:0]    pix_data_s1,
    output logic                pix_ready_s1,
    output logic [PIX_W-1:0]    pixel_s1,
    output logic [NUM_COLS-1:0] wrapout_s1,
    output logic [NUM_ROWS-1:0] Mem_Pointer_s1,
    output logic [PIX_W-1:0]    Pix_Mux_s1,
    output logic                Write_Mem_s1,
    output logic                row_done_s1,
    output logic                rows_filled_s1
);

    localparam int unsigned      CNT_W     = $clog2(NUM_ROWS + 1);
    localparam logic [CNT_W-1:0] ROWS_FULL = CNT_W'(NUM_ROWS);
    localparam logic [CNT_W-1:0] ROWS_LAST = CNT_W'(NUM_ROWS - 1);

    state_e              state;
    state_e              state_nxt;
    logic                started;
    logic                accept;
    logic                in_write;
    logic [NUM_COLS-1:0] col_ring;
    logic [PIX_W-1:0]    mux_ring;
    logic [CNT_W-1:0]    row_cnt;

    // ready is held low for the first cycle after reset, then tracks WAIT
    assign pix_ready_s1 = started && (state == WAIT);
    assign accept       = pix_valid_s1 && pix_ready_s1;
    assign in_write     = (state == WRITE);

    always_ff @(posedge phi1) begin
        if (!reset_b_s1) begin
            state   <= WAIT;
            started <= 1'b0;
        end else begin
            state   <= state_nxt;
            started <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT:    if (accept) state_nxt = SCAN;
            SCAN:    if (mux_ring[PIX_W-1]) state_nxt = WRITE;
            WRITE:   state_nxt = WAIT;
            default: state_nxt = WAIT;
        endcase
    end

    always_ff @(posedge phi1) begin
        if (!reset_b_s1) begin
            pixel_s1 <= '0;
        end else if (accept) begin
            pixel_s1 <= pix_data_s1;
        end
    end

    always_ff @(posedge phi1) begin
        if (!reset_b_s1) begin
            row_cnt <= '0;
        end else if (row_done_s1 && (row_cnt != ROWS_FULL)) begin
            row_cnt <= row_cnt + 1'b1;
        end
    end

    onehot_ring #(
        .WIDTH     (NUM_COLS),
        .RESET_VAL ({1'b1, {(NUM_COLS-1){1'b0}}}),
        .DIR       (DIR_RIGHT)
    ) u_col_ring (
        .clk     (phi1),
        .reset_b (reset_b_s1),
        .clear   (1'b0),
        .advance (in_write),
        .ring    (col_ring)
    );

    onehot_ring #(
        .WIDTH     (NUM_ROWS),
        .RESET_VAL (NUM_ROWS'(1)),
        .DIR       (DIR_LEFT)
    ) u_memptr_ring (
        .clk     (phi1),
        .reset_b (reset_b_s1),
        .clear   (1'b0),
        .advance (row_done_s1),
        .ring    (Mem_Pointer_s1)
    );

    // bit-select rewinds to bit 0 on the write cycle, ready for the next column
    onehot_ring #(
        .WIDTH     (PIX_W),
        .RESET_VAL (PIX_W'(1)),
        .DIR       (DIR_LEFT)
    ) u_mux_ring (
        .clk     (phi1),
        .reset_b (reset_b_s1),
        .clear   (in_write),
        .advance ((state == SCAN) && !mux_ring[PIX_W-1]),
        .ring    (mux_ring)
    );

    assign wrapout_s1     = (state == WAIT) ? '0 : col_ring;
    assign Pix_Mux_s1     = (state == WAIT) ? '0 : mux_ring;
    assign Write_Mem_s1   = in_write;
    assign row_done_s1    = in_write && col_ring[0];
    assign rows_filled_s1 = (row_cnt == ROWS_FULL) || (row_done_s1 && (row_cnt == ROWS_LAST));

endmodule
